// File: rtl/pipe_pkg.sv
// Shared definitions for the IF/ID stage: occupancy encoding, bubble
// instruction default and a saturating adder.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_e;

   localparam logic [31:0] BUBBLE_INSTR_DEF = 32'h0000_0000;

   // Adds with a 33-bit intermediate so the compare against max_val never sees a wrapped sum.
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] max_val);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
   endfunction

endpackage

// File: rtl/if_id_skid_reg_if.sv
// Valid/ready beat bundle carrying a PC and an instruction; the master
// drives the beat, the slave drives ready.
interface if_id_skid_reg_if #(
   parameter int PC_W    = 32,
   parameter int INSTR_W = 32
);
   logic               valid;
   logic               ready;
   logic [PC_W-1:0]    pc;
   logic [INSTR_W-1:0] instr;

   modport master (output valid, output pc, output instr, input  ready);
   modport slave  (input  valid, input  pc, input  instr, output ready);
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter: adds inc_i on each enabled edge, sticks at all-ones.
module sat_counter
   import pipe_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic [1:0]       inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   localparam logic [31:0] MAX_VAL = 32'({CNT_W{1'b1}});

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_o <= '0;
      end else if (en_i) begin
         cnt_o <= CNT_W'(sat_add(32'(cnt_o), 32'(inc_i), MAX_VAL));
      end
   end

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register: plain register (DEPTH=1) or two-entry skid buffer
// (DEPTH=2) with synchronous flush and a saturating flush-drop counter.
module if_id_skid_reg
   import pipe_pkg::*;
#(
   parameter int                   PC_W         = 32,
   parameter int                   INSTR_W      = 32,
   parameter int                   DEPTH        = 2,
   parameter logic [INSTR_W-1:0]   BUBBLE_INSTR = INSTR_W'(BUBBLE_INSTR_DEF),
   parameter int                   CNT_W        = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   if_id_skid_reg_if.slave        up,
   if_id_skid_reg_if.master       dn,
   input  logic                   flush_i,
   output logic [1:0]             occ_o,
   output logic [CNT_W-1:0]       drop_cnt_o
);

   state_e             state_q, state_d;
   logic [PC_W-1:0]    head_pc_q, skid_pc_q;
   logic [INSTR_W-1:0] head_instr_q, skid_instr_q;
   logic               load_head_in, load_head_skid, load_skid;
   logic               in_fire, out_fire;
   logic [1:0]         drop_inc;

   assign in_fire  = up.valid & up.ready;
   assign out_fire = dn.valid & dn.ready;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no latch is inferred.
      state_d        = state_q;
      load_head_in   = 1'b0;
      load_head_skid = 1'b0;
      load_skid      = 1'b0;
      unique case (state_q)
         ST_EMPTY: begin
            if (in_fire) begin
               state_d      = ST_ONE;
               load_head_in = 1'b1;
            end
         end
         ST_ONE: begin
            if (in_fire && out_fire) begin
               load_head_in = 1'b1;
            end else if (in_fire && DEPTH == 2) begin
               state_d   = ST_TWO;
               load_skid = 1'b1;
            end else if (out_fire) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (out_fire) begin
               state_d        = ST_ONE;
               load_head_skid = 1'b1;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      // Flush overrides everything, including a beat arriving this cycle.
      if (flush_i) begin
         state_d        = ST_EMPTY;
         load_head_in   = 1'b0;
         load_head_skid = 1'b0;
         load_skid      = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rst_i) begin
         state_q      <= ST_EMPTY;
         head_pc_q    <= '0;
         head_instr_q <= BUBBLE_INSTR;
         skid_pc_q    <= '0;
         skid_instr_q <= BUBBLE_INSTR;
      end else begin
         state_q <= state_d;
         if (flush_i) begin
            head_pc_q    <= '0;
            head_instr_q <= BUBBLE_INSTR;
         end else if (load_head_in) begin
            head_pc_q    <= up.pc;
            head_instr_q <= up.instr;
         end else if (load_head_skid) begin
            head_pc_q    <= skid_pc_q;
            head_instr_q <= skid_instr_q;
         end
         if (load_skid) begin
            skid_pc_q    <= up.pc;
            skid_instr_q <= up.instr;
         end
      end
   end

   generate
      if (DEPTH == 2) begin : g_skid_ready
         logic ready_q;
         // Registered ready cuts the decode-stall path back into fetch.
         always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) ready_q <= 1'b1;
            else        ready_q <= (state_d != ST_TWO);
         end
         assign up.ready = ready_q;
      end else begin : g_plain_ready
         assign up.ready = !dn.valid | dn.ready;
      end
   endgenerate

   assign dn.valid = (state_q != ST_EMPTY);
   assign dn.pc    = dn.valid ? head_pc_q    : '0;
   assign dn.instr = dn.valid ? head_instr_q : BUBBLE_INSTR;
   assign occ_o    = 2'(state_q);

   // A head beat taken by decode in the flush cycle is delivered, not dropped.
   assign drop_inc = 2'(3'(occ_o) + 3'(in_fire) - 3'(out_fire));

   sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (flush_i),
      .inc_i (drop_inc),
      .cnt_o (drop_cnt_o)
   );

endmodule
